pix_frame_tx: RTL

- Transmit-side framer for the pixel link: the counterpart of the receive parser that turns UART bytes into 12-bit pixels and a check code.
- Accepts a frame request plus a stream of 12-bit pixels and serialises them into the framed byte sequence the receive side parses.
- Drives the uart_tx byte interface (data plus 1-cycle valid) and paces bytes so uart_tx is never overrun.
- Sits between a pixel source and uart_tx / o_wifi_rxd.

---
 rtl/pix_frame_tx.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/pix_frame_tx.sv
// pix_frame_tx: frames a pixel burst as A5, N, {0,p[11:8]}, p[7:0} per pixel, CHK for uart_tx.
// Latency: header strobed the cycle after i_start; every later byte at least BYTE_CYCLES after the previous one.
// Backpressure: o_pix_ready only when a hi byte may go out; waits indefinitely on i_pix_valid low.
// Optional: define SND_ACK_EN to wait for the receiver's CHK echo (or a timeout) before ending the frame.
module pix_frame_tx #(
  parameter int CLK_FRE     = 50,
  parameter int BAUD_RATE   = 9600,
  parameter int PARITY_ON   = 0,
  parameter int GUARD_BITS  = 1,
  parameter int ACK_TIMEOUT = 5000000
) (
  input  logic        i_clk_sys,
  input  logic        i_rst_n,
  input  logic        i_start,
  input  logic [7:0]  i_len,
  input  logic [11:0] i_pix,
  input  logic        i_pix_valid,
  output logic        o_pix_ready,
  output logic [7:0]  o_tx_data,
  output logic        o_tx_valid,
  output logic        o_busy,
  output logic        o_frame_done,
  input  logic [7:0]  i_rx_data,
  input  logic        i_rx_done,
  output logic        o_ack_ok,
  output logic        o_ack_err
);

  localparam int BIT_CYCLES  = CLK_FRE * 1000000 / BAUD_RATE;
  localparam int BYTE_CYCLES = BIT_CYCLES * (10 + PARITY_ON + GUARD_BITS);
  localparam int GW          = $clog2(BYTE_CYCLES + 1);
  localparam logic [GW-1:0] GAP_LOAD = GW'(BYTE_CYCLES - 1);

  // Each state names the byte currently being paced on the line; the next
  // byte leaves (and the state advances) once the gap counter has drained.
`ifdef SND_ACK_EN
  typedef enum logic [2:0] {IDLE, HDR, LEN, PIX_HI, PIX_LO, CHK, ACK, DONE} state_t;
`else
  typedef enum logic [2:0] {IDLE, HDR, LEN, PIX_HI, PIX_LO, CHK, DONE} state_t;
`endif

  state_t      state, state_nxt;
  logic [GW-1:0] gap;
  logic [7:0]  len_q, rem, lo_q, chk;
  logic [7:0]  tx_data_q;
  logic        tx_valid_q;
  logic        emit, acc, pix_rdy;
  logic [7:0]  emit_byte;
  logic        gap_zero, start_ok, accept;
  logic        ack_done;

  assign gap_zero = (gap == '0);
  assign start_ok = i_start && (i_len != 8'd0);
  assign accept   = pix_rdy && i_pix_valid;

`ifdef SND_ACK_EN
  localparam int TW = $clog2(ACK_TIMEOUT + 1);
  logic [TW-1:0] tmo;
  logic          ack_seen, ack_ok_q, ack_err_q;
  logic          rx_evt, tmo_evt;

  assign rx_evt   = (state == ACK) && !ack_seen && i_rx_done;
  assign tmo_evt  = (state == ACK) && !ack_seen && !i_rx_done && (tmo == TW'(ACK_TIMEOUT - 1));
  assign ack_done = ack_seen && gap_zero;
  assign o_ack_ok  = ack_ok_q;
  assign o_ack_err = ack_err_q;

  // Echo check: timeout counts from the CHK strobe; first echo or timeout decides the result.
  always_ff @(posedge i_clk_sys) begin
    if (!i_rst_n) begin
      tmo       <= '0;
      ack_seen  <= 1'b0;
      ack_ok_q  <= 1'b0;
      ack_err_q <= 1'b0;
    end else begin
      if (emit && state == PIX_LO)
        tmo <= '0;
      else if ((state == CHK || state == ACK) && tmo != TW'(ACK_TIMEOUT - 1))
        tmo <= tmo + 1'b1;
      ack_seen  <= (state == ACK) && (ack_seen || rx_evt || tmo_evt);
      ack_ok_q  <= rx_evt && (i_rx_data == chk);
      ack_err_q <= (rx_evt && (i_rx_data != chk)) || tmo_evt;
    end
  end
`else
  logic unused_rx;
  assign unused_rx = ^{i_rx_data, i_rx_done, ACK_TIMEOUT[0]};
  assign ack_done  = 1'b0;
  assign o_ack_ok  = 1'b0;
  assign o_ack_err = 1'b0;
`endif

  // State register.
  always_ff @(posedge i_clk_sys) begin
    if (!i_rst_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // Next-state: advance when the paced byte has drained and the next one can leave.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:   if (start_ok) state_nxt = HDR;
      HDR:    if (gap_zero) state_nxt = LEN;
      LEN:    if (accept) state_nxt = PIX_HI;
      PIX_HI: if (gap_zero) state_nxt = PIX_LO;
      PIX_LO: if (accept) state_nxt = PIX_HI;
              else if (gap_zero && rem == 8'd0) state_nxt = CHK;
`ifdef SND_ACK_EN
      CHK:    state_nxt = ACK;
      ACK:    if (ack_done) state_nxt = DONE;
`else
      CHK:    if (gap_zero) state_nxt = DONE;
`endif
      DONE:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs: pick the byte to strobe this edge and whether it feeds the check code.
  always_comb begin
    pix_rdy   = 1'b0;
    emit      = 1'b0;
    emit_byte = 8'h00;
    acc       = 1'b0;
    case (state)
      IDLE:   if (start_ok) begin emit = 1'b1; emit_byte = 8'hA5; end
      HDR:    if (gap_zero) begin emit = 1'b1; emit_byte = len_q; acc = 1'b1; end
      LEN:    pix_rdy = gap_zero;
      PIX_HI: if (gap_zero) begin emit = 1'b1; emit_byte = lo_q; acc = 1'b1; end
      PIX_LO: if (gap_zero) begin
                if (rem != 8'd0) pix_rdy = 1'b1;
                else begin emit = 1'b1; emit_byte = chk; end
              end
      default: ;
    endcase
    if (pix_rdy && i_pix_valid) begin
      emit      = 1'b1;
      emit_byte = {4'h0, i_pix[11:8]};
      acc       = 1'b1;
    end
    o_pix_ready  = pix_rdy;
    o_busy       = (state != IDLE);
    o_frame_done = (state == DONE);
    o_tx_valid   = tx_valid_q;
    o_tx_data    = tx_data_q;
  end

  // Datapath: byte register, pacing counter, pixel bookkeeping and running check code.
  always_ff @(posedge i_clk_sys) begin
    if (!i_rst_n) begin
      tx_valid_q <= 1'b0;
      tx_data_q  <= 8'h00;
      gap        <= '0;
      len_q      <= 8'h00;
      rem        <= 8'h00;
      lo_q       <= 8'h00;
      chk        <= 8'h00;
    end else begin
      tx_valid_q <= emit;
      if (emit) begin
        tx_data_q <= emit_byte;
        gap       <= GAP_LOAD;
      end else if (!gap_zero) begin
        gap <= gap - 1'b1;
      end
      if (state == IDLE && start_ok) begin
        len_q <= i_len;
        rem   <= i_len;
        chk   <= 8'h00;
      end else if (acc) begin
        chk <= chk ^ emit_byte;
      end
      if (accept) begin
        lo_q <= i_pix[7:0];
        rem  <= rem - 8'd1;
      end
    end
  end

endmodule
